// File: rtl/multiplexer_io_pipelined.sv
// Pipelined N:1 routing mux with a serially loaded, atomically committed selector.
// Define MULTIPLEXER_IO_PIPELINED_OOR_FLAG_EN to add the sel_error output.
module multiplexer_io_pipelined #(
  parameter int N_INPUTS  = 10,
  parameter int SEL_WIDTH = 4,
  parameter int PIPELINED = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                config_en,
  input  logic                config_in,
  output logic                config_out,
  input  logic                config_commit,
  input  logic [N_INPUTS-1:0] data_in,
  input  logic                data_valid_in,
  output logic                data_out,
  output logic                data_valid_out
`ifdef MULTIPLEXER_IO_PIPELINED_OOR_FLAG_EN
  ,
  output logic                sel_error
`endif
);

  localparam int TREE_W    = 1 << SEL_WIDTH;
  localparam int SEL_TOT   = (SEL_WIDTH * (SEL_WIDTH - 1)) / 2;
  localparam int SEL_TOT_W = (SEL_TOT > 0) ? SEL_TOT : 1;
  localparam int DEPTH     = (PIPELINED != 0) ? SEL_WIDTH : 1;

  // Base offset of the r-bit remaining-selector field in the packed selector pipeline.
  function automatic int sel_off(input int r);
    return (r * (r - 1)) / 2;
  endfunction

  // ---------------------------------------------------------------------------
  // Configuration chain: shadow shift register, active selector, chain output
  // ---------------------------------------------------------------------------
  logic [SEL_WIDTH-1:0] shadow_q;
  logic [SEL_WIDTH-1:0] active_q;
  logic                 config_out_q;

  // NOTE: non-blocking assignments make the commit capture the pre-shift shadow
  // value when config_en and config_commit are both high on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q     <= '0;
      active_q     <= '0;
      config_out_q <= 1'b0;
    end else begin
      if (config_en) begin
        shadow_q     <= {shadow_q[SEL_WIDTH-2:0], config_in};
        config_out_q <= shadow_q[SEL_WIDTH-1];
      end
      if (config_commit) begin
        active_q <= shadow_q;
      end
    end
  end

  assign config_out = config_out_q;

  // ---------------------------------------------------------------------------
  // Tree entry: pad to a power of two and zero-gate invalid samples
  // ---------------------------------------------------------------------------
  logic [TREE_W-1:0] padded;
  logic [TREE_W-1:0] tree_in;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    padded                 = '0;
    padded[N_INPUTS-1:0]   = data_in;
  end

  assign tree_in = data_valid_in ? padded : '0;

  // ---------------------------------------------------------------------------
  // Binary mux tree. Level outputs are packed heap-style: the W-bit result of a
  // level sits at [2W-1:W], so the final selected bit is bit 1.
  // ---------------------------------------------------------------------------
  logic [TREE_W-1:1]    tree_d;
  logic [TREE_W-1:1]    tree_src;
  logic [SEL_TOT_W-1:0] sel_d;
  logic [SEL_TOT_W-1:0] sel_src;
  logic                 data_bit;

  for (genvar j = 0; j < SEL_WIDTH; j++) begin : g_lvl
    localparam int R = SEL_WIDTH - 1 - j;
    localparam int W = 1 << R;

    logic [2*W-1:0] vec_in;
    logic [R:0]     sel_in;

    if (j == 0) begin : g_first
      assign vec_in = tree_in;
      assign sel_in = active_q;
    end else begin : g_next
      assign vec_in = tree_src[4*W-1:2*W];
      assign sel_in = sel_src[sel_off(R+1)+R:sel_off(R+1)];
    end

    // Selector bit set picks the upper half, matching MSB-first index order.
    assign tree_d[2*W-1:W] = sel_in[R] ? vec_in[2*W-1:W] : vec_in[W-1:0];

    if (R > 0) begin : g_sel
      assign sel_d[sel_off(R)+R-1:sel_off(R)] = sel_in[R-1:0];
    end
  end

  if (PIPELINED != 0) begin : g_pipe
    logic [TREE_W-1:1]    tree_q;
    logic [SEL_TOT_W-1:0] sel_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        tree_q <= '0;
        sel_q  <= '0;
      end else begin
        tree_q <= tree_d;
        sel_q  <= sel_d;
      end
    end

    assign tree_src = tree_q;
    assign sel_src  = sel_q;
    assign data_bit = tree_q[1];
  end else begin : g_comb
    logic out_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        out_q <= 1'b0;
      end else begin
        out_q <= tree_d[1];
      end
    end

    assign tree_src = tree_d;
    assign sel_src  = sel_d;
    assign data_bit = out_q;
  end

  assign data_out = data_bit;

  // ---------------------------------------------------------------------------
  // Valid (and optional out-of-range flag) travel with the sample
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;

  always_comb begin
    valid_d    = valid_q << 1;
    valid_d[0] = data_valid_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign data_valid_out = valid_q[DEPTH-1];

`ifdef MULTIPLEXER_IO_PIPELINED_OOR_FLAG_EN
  logic             oor_in;
  logic [DEPTH-1:0] err_q;
  logic [DEPTH-1:0] err_d;

  assign oor_in = int'(active_q) >= N_INPUTS;

  always_comb begin
    err_d    = err_q << 1;
    err_d[0] = data_valid_in & oor_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign sel_error = err_q[DEPTH-1];
`endif

endmodule
